// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: FSM state type, CRC-32 constants, beat
// geometry and small byte-lane helpers used by the FCS inserter and its
// CRC engine.
package eth_pkg;

    // Streaming beat geometry.
    localparam int BEAT_BYTES = 8;
    localparam int BEAT_BITS  = 8 * BEAT_BYTES;

    // Frame byte counter width and saturation value.
    localparam int              CNT_W   = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = 7'd127;

    // Smallest legal Ethernet frame, FCS excluded.
    localparam int ETH_MIN_FRAME_BYTES = 60;

    // IEEE 802.3 CRC-32 polynomial, its bit-reversed form for the
    // LSB-first (reflected) shift register, and the standard seed.
    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = {<<{CRC32_POLY}};
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // Inserter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2,
        ST_FCS  = 2'd3
    } state_e;

    // Advance a reflected CRC-32 register by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Number of set bits in a byte-valid mask (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(keep[i]);
        end
        return n;
    endfunction

    // Contiguous byte-valid mask with the low n lanes set (n = 0..8).
    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (4'(i) < n);
        end
        return m;
    endfunction

    // Expand a byte-valid mask into a 64-bit data mask.
    function automatic logic [BEAT_BITS-1:0] lane_mask64(input logic [7:0] keep);
        logic [BEAT_BITS-1:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

    // Byte counter increment that sticks at CNT_MAX.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [3:0]       n);
        logic [CNT_W:0] s;
        s = {1'b0, cnt} + {4'd0, n};
        return (s > {1'b0, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/crc32.sv
// Parallel reflected CRC-32 over a byte-sliced beat. Bytes whose in_valid
// bit is set are folded in lane order (lane 0 first). in_crc_reset reloads
// the seed after the current beat has been folded, so the beat carrying it
// still contributes to out_crc.
import eth_pkg::*;

module crc32 #(
    parameter int          SLICE_LENGTH    = 8,
    parameter logic [31:0] INITIAL_CRC     = CRC32_INIT,
    parameter bit          REGISTER_OUTPUT = 1'b0,
    parameter bit          INVERT_OUTPUT   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*SLICE_LENGTH-1:0] in_data,
    input  logic [SLICE_LENGTH-1:0]   in_valid,
    input  logic                      in_crc_reset,
    output logic [31:0]               out_crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_next;
    logic [31:0] crc_view;

    // Fold the valid bytes of this beat into the running remainder.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        crc_next = crc_q;
        for (int i = 0; i < SLICE_LENGTH; i++) begin
            if (in_valid[i]) begin
                crc_next = crc32_byte(crc_next, in_data[8*i +: 8]);
            end
        end
        crc_d    = in_crc_reset ? INITIAL_CRC : crc_next;
        crc_view = INVERT_OUTPUT ? ~crc_next : crc_next;
    end

    // Running remainder register, reseeded by reset or end of frame.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q <= INITIAL_CRC;
        end else begin
            crc_q <= crc_d;
        end
    end

    if (REGISTER_OUTPUT) begin : g_out_reg
        logic [31:0] out_q;

        // Optional output register for timing-critical consumers.
        always_ff @(posedge clk) begin
            if (!rst) begin
                out_q <= '0;
            end else begin
                out_q <= crc_view;
            end
        end
        assign out_crc = out_q;
    end else begin : g_out_comb
        assign out_crc = crc_view;
    end

endmodule

// File: rtl/eth_tx_fcs_insert.sv
// Ethernet TX FCS inserter: passes a 64-bit AXI-Stream frame through a
// one-beat output register, optionally zero-pads it to MIN_FRAME_BYTES,
// and appends the 4-byte CRC-32 FCS immediately after the last byte. When
// the FCS does not fit in the last beat, its remaining bytes follow in one
// extra beat.
// Build option: define ETH_TX_PAD_EN to enable minimum-length padding;
// without it the PAD state is never entered and MIN_FRAME_BYTES is ignored.
import eth_pkg::*;

module eth_tx_fcs_insert #(
    parameter int          MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
    parameter logic [31:0] INITIAL_CRC     = CRC32_INIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BEAT_BITS-1:0] s_tdata,
    input  logic [7:0]           s_tkeep,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [BEAT_BITS-1:0] m_tdata,
    output logic [7:0]           m_tkeep,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready
);

    if (MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > int'(CNT_MAX)) begin : g_bad_min
        $error("eth_tx_fcs_insert: MIN_FRAME_BYTES must lie in 1..127");
    end

    state_e               state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [BEAT_BITS-1:0] m_tdata_q,  m_tdata_d;
    logic [7:0]           m_tkeep_q,  m_tkeep_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 m_tlast_q,  m_tlast_d;
    logic [31:0]          rem_q,      rem_d;
    logic [7:0]           rem_keep_q, rem_keep_d;

    logic                 out_ready;
    logic                 fire;
    logic [3:0]           in_cnt;
    logic [BEAT_BITS-1:0] beat_data;
    logic [3:0]           beat_ce;
    logic                 beat_emit;
    logic                 beat_final;
    logic                 pad_next;
    logic [CNT_W-1:0]     cnt_upd;
    logic [7:0]           crc_keep;
    logic [31:0]          crc_fcs;
    logic [95:0]          fcs_wide;

    // The output register can take a new beat when empty or being drained.
    assign out_ready = !m_tvalid_q || m_tready;
    assign s_tready  = rst && out_ready && (state_q == ST_IDLE || state_q == ST_DATA);
    assign fire      = s_tvalid && s_tready;

    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;

    // Decide the content of the beat being emitted this cycle: how many
    // data/pad lanes it carries (beat_ce) and whether the FCS follows it.
    always_comb begin
        in_cnt     = popcount8(s_tkeep);
        beat_data  = '0;
        beat_ce    = 4'd0;
        beat_emit  = 1'b0;
        beat_final = 1'b0;
        pad_next   = 1'b0;
        cnt_upd    = cnt_q;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (fire) begin
                    beat_emit = 1'b1;
                    // Lanes past the last valid byte become zero pad or FCS.
                    beat_data = s_tdata & lane_mask64(s_tkeep);
                    if (!s_tlast) begin
                        beat_ce = 4'd8;
                        cnt_upd = sat_add(cnt_q, in_cnt);
                    end else begin
`ifdef ETH_TX_PAD_EN
                        if (int'(cnt_q) + int'(in_cnt) >= MIN_FRAME_BYTES) begin
                            beat_ce    = in_cnt;
                            beat_final = 1'b1;
                        end else if (MIN_FRAME_BYTES - int'(cnt_q) <= BEAT_BYTES) begin
                            beat_ce    = 4'(MIN_FRAME_BYTES - int'(cnt_q));
                            beat_final = 1'b1;
                        end else begin
                            beat_ce  = 4'd8;
                            pad_next = 1'b1;
                            cnt_upd  = sat_add(cnt_q, 4'd8);
                        end
`else
                        beat_ce    = in_cnt;
                        beat_final = 1'b1;
`endif
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            ST_PAD: begin
                if (out_ready) begin
                    beat_emit = 1'b1;
                    if (MIN_FRAME_BYTES - int'(cnt_q) > BEAT_BYTES) begin
                        beat_ce = 4'd8;
                        cnt_upd = sat_add(cnt_q, 4'd8);
                    end else begin
                        beat_ce    = 4'(MIN_FRAME_BYTES - int'(cnt_q));
                        beat_final = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
        crc_keep = beat_emit ? keep_mask(beat_ce) : 8'h00;
    end

    crc32 #(
        .SLICE_LENGTH    (BEAT_BYTES),
        .INITIAL_CRC     (INITIAL_CRC),
        .REGISTER_OUTPUT (1'b0),
        .INVERT_OUTPUT   (1'b1)
    ) u_crc32 (
        .clk          (clk),
        .rst          (rst),
        .in_data      (beat_data),
        .in_valid     (crc_keep),
        .in_crc_reset (beat_final),
        .out_crc      (crc_fcs)
    );

    // Assemble the output beat, splice in the FCS and step the FSM.
    always_comb begin
        state_d    = state_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        rem_d      = rem_q;
        rem_keep_d = rem_keep_q;
        // FCS shifted up to the first free lane; bits 95:64 are the bytes
        // that spill into the following beat.
        fcs_wide   = {64'd0, crc_fcs} << {beat_ce, 3'b000};

        if (out_ready) begin
            m_tvalid_d = 1'b0;
            m_tdata_d  = '0;
            m_tkeep_d  = 8'h00;
            m_tlast_d  = 1'b0;
            if (state_q == ST_FCS) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = {32'd0, rem_q};
                m_tkeep_d  = rem_keep_q;
                m_tlast_d  = 1'b1;
                state_d    = ST_IDLE;
            end else if (beat_emit) begin
                m_tvalid_d = 1'b1;
                if (!beat_final) begin
                    m_tdata_d = beat_data;
                    m_tkeep_d = 8'hFF;
                    state_d   = (pad_next || state_q == ST_PAD) ? ST_PAD : ST_DATA;
                end else begin
                    m_tdata_d = beat_data | fcs_wide[63:0];
                    if (beat_ce > 4'd4) begin
                        m_tkeep_d  = 8'hFF;
                        rem_d      = fcs_wide[95:64];
                        rem_keep_d = keep_mask(beat_ce - 4'd4);
                        state_d    = ST_FCS;
                    end else begin
                        m_tkeep_d = keep_mask(beat_ce + 4'd4);
                        m_tlast_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
        end

        cnt_d = (state_d == ST_IDLE) ? '0 : cnt_upd;
    end

    // Register FSM, byte counter, pending FCS bytes and the output stage.
    // NOTE: reset is synchronous and active-low here, so it is sampled only on a rising clk edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= 8'h00;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            rem_q      <= '0;
            rem_keep_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            rem_q      <= rem_d;
            rem_keep_q <= rem_keep_d;
        end
    end

endmodule
